wb_sum_sequencer: RTL and testbench

Wishbone-mapped controller that sequences a shared 32-bit adder over a queue of operands written by the management SoC. Operands are pushed into an internal FIFO; a start command makes an FSM pop one operand per cycle into an accumulator until the FIFO is empty. The block then reports the result, the operand count and the overflow status through registers and an interrupt. It sits in the user project area beside the existing two-operand adder slave and uses the same address window and ack style.

---
 rtl/wb_sum_sequencer.sv | 169 ++++++++++++++++
 tb/tb_wb_sum_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/wb_sum_sequencer.sv
// wb_sum_sequencer
//   Wishbone slave that queues 32-bit operands in a FIFO and, on a start
//   command, sums them one per cycle into a wrapping 32-bit accumulator.
//   It reports the result, operand count, overflow and FIFO status through
//   registers, and raises a done interrupt.
//
// Ports
//   wb_clk_i   : clock
//   wb_rst_i   : asynchronous active-high reset
//   wbs_stb_i  : strobe
//   wbs_cyc_i  : cycle
//   wbs_we_i   : write enable
//   wbs_sel_i  : byte selects; writes act only when all four are set
//   wbs_dat_i  : write data
//   wbs_adr_i  : byte address; [31:28] selects the block, [7:2] the register
//   wbs_ack_o  : registered single-cycle acknowledge
//   wbs_dat_o  : registered read data, held between reads
//   irq        : irq[0] = done & irq_en, irq[2:1] = 0
//
// Register map (word offsets)
//   0 CTRL   W: [0] start, [1] clear, [2] irq_en   R: {29'b0, irq_en, 2'b0}
//   1 STATUS R: [0] busy, [1] done, [2] full, [3] empty, [9:4] level,
//               [10] ovf, [11] err
//   2 PUSH   W: enqueue operand                    R: 0
//   3 RESULT R: accumulator
//   4 COUNT  R: operands summed since last start/clear
module wb_sum_sequencer #(
    parameter int         FIFO_DEPTH  = 16,
    parameter logic [3:0] BASE_NIBBLE = 4'h3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [2:0]  irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = 1;
    localparam logic [AW:0]   LVL_ONE   = 1;
    localparam logic [AW:0]   LVL_FULL  = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   level;
    logic [31:0]   acc, count;
    logic          done, ovf, err, irq_en;

    // Address bits outside the window nibble and word offset are don't-care.
    logic unused_adr;
    assign unused_adr = ^{wbs_adr_i[27:8], wbs_adr_i[1:0]};

    // An access is taken only when no ack is pending, so a held request is
    // acted on once and acked every second cycle.
    logic       valid, wr_ok, ctrl_wr, cmd_start, cmd_clear, push_req;
    logic       push_ok, pop, fifo_full, fifo_empty;
    logic [5:0] offset;
    logic [32:0] sum;

    assign valid      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == BASE_NIBBLE) & ~wbs_ack_o;
    assign offset     = wbs_adr_i[7:2];
    assign wr_ok      = valid & wbs_we_i & (wbs_sel_i == 4'hF);
    assign ctrl_wr    = wr_ok & (offset == 6'd0);
    assign cmd_clear  = ctrl_wr & wbs_dat_i[1];
    assign cmd_start  = ctrl_wr & wbs_dat_i[0] & ~wbs_dat_i[1];  // clear wins
    assign push_req   = wr_ok & (offset == 6'd2);
    assign fifo_full  = (level == LVL_FULL);
    assign fifo_empty = (level == '0);
    assign push_ok    = push_req & ~fifo_full;
    assign pop        = (state == RUN) & ~fifo_empty;
    assign sum        = {1'b0, acc} + {1'b0, mem[rptr]};

    assign irq = {2'b00, done & irq_en};

    logic [31:0] rdata;
    always_comb begin
        rdata = 32'h0;
        case (offset)
            6'd0: rdata = {29'b0, irq_en, 2'b0};
            6'd1: rdata = {20'b0, err, ovf, 6'(level), fifo_empty, fifo_full,
                           done, state == RUN};
            6'd3: rdata = acc;
            6'd4: rdata = count;
            default: rdata = 32'h0;
        endcase
    end

    // Operand storage needs no reset; the pointers define what is valid.
    always_ff @(posedge wb_clk_i) begin
        if (push_ok) mem[wptr] <= wbs_dat_i;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            acc       <= 32'h0;
            count     <= 32'h0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            irq_en    <= 1'b0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0;
        end else begin
            wbs_ack_o <= valid;
            if (valid && !wbs_we_i) wbs_dat_o <= rdata;
            if (ctrl_wr) irq_en <= wbs_dat_i[2];

            if (cmd_clear) begin
                state <= IDLE;
                wptr  <= '0;
                rptr  <= '0;
                level <= '0;
                acc   <= 32'h0;
                count <= 32'h0;
                done  <= 1'b0;
                ovf   <= 1'b0;
                err   <= 1'b0;
            end else begin
                if (push_ok) wptr <= wptr + PTR_ONE;
                if (push_req && fifo_full) err <= 1'b1;
                if (pop) rptr <= rptr + PTR_ONE;
                case ({push_ok, pop})
                    2'b10:   level <= level + LVL_ONE;
                    2'b01:   level <= level - LVL_ONE;
                    default: level <= level;
                endcase

                case (state)
                    IDLE, DONE: begin
                        if (cmd_start) begin
                            state <= RUN;
                            acc   <= 32'h0;
                            count <= 32'h0;
                            ovf   <= 1'b0;
                            done  <= 1'b0;
                        end
                    end
                    RUN: begin
                        // A start here is ignored; the run ends on the first
                        // cycle the FIFO is seen empty.
                        if (!fifo_empty) begin
                            acc   <= sum[31:0];
                            count <= count + 32'd1;
                            if (sum[32]) ovf <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_sum_sequencer.sv
module tb_wb_sum_sequencer;

    localparam logic [31:0] A_CTRL   = 32'h3000_0000;
    localparam logic [31:0] A_STATUS = 32'h3000_0004;
    localparam logic [31:0] A_PUSH   = 32'h3000_0008;
    localparam logic [31:0] A_RESULT = 32'h3000_000C;
    localparam logic [31:0] A_COUNT  = 32'h3000_0010;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] dat_i, adr;
    logic        ack;
    logic [31:0] dat_o;
    logic [2:0]  irq;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];

    wb_sum_sequencer #(.FIFO_DEPTH(16), .BASE_NIBBLE(4'h3)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_dat_i(dat_i),
        .wbs_adr_i(adr),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat_o),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_i = d; sel = s;
        do begin @(posedge clk); #1; n++; end while (!ack && n < 8);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!ack) chk("wr_ack", {31'b0, ack}, 32'd1);
    endtask

    task automatic wb_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
        int n = 0;
        logic [31:0] e;
        exp_q.push_back(exp);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        do begin @(posedge clk); #1; n++; end while (!ack && n < 8);
        cyc = 1'b0; stb = 1'b0;
        e = exp_q.pop_front();
        if (ack) chk(tag, dat_o, e);
        else     chk({tag, "_ack"}, {31'b0, ack}, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] words[17];
    logic [32:0] msum;
    logic        movf;
    int          acks;

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        dat_i = 32'h0; adr = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_irq", {29'b0, irq}, 32'd0);
        @(posedge clk); #1;

        wb_read(A_STATUS, 32'h0000_0008, "rst_status");
        wb_read(A_RESULT, 32'h0, "rst_result");

        // Basic sum with busy timing: RUN spans 4 cycles for 3 operands.
        wb_write(A_PUSH, 32'd5, 4'hF);
        wb_write(A_PUSH, 32'd7, 4'hF);
        wb_write(A_PUSH, 32'h10, 4'hF);
        wb_write(A_CTRL, 32'h5, 4'hF);
        wb_read(A_STATUS, 32'h0000_0021, "run_status0");
        wb_read(A_STATUS, 32'h0000_0009, "run_status1");
        wb_read(A_STATUS, 32'h0000_000A, "run_status2");
        wb_read(A_RESULT, 32'h1C, "sum3_result");
        wb_read(A_COUNT, 32'd3, "sum3_count");
        chk("sum3_irq", {29'b0, irq}, 32'd1);
        wb_read(A_CTRL, 32'h4, "ctrl_read");

        // Overflow: restart from DONE, irq_en dropped by this CTRL write.
        wb_write(A_PUSH, 32'hFFFF_FFFF, 4'hF);
        wb_write(A_PUSH, 32'd2, 4'hF);
        wb_write(A_CTRL, 32'h1, 4'hF);
        idle(10);
        wb_read(A_RESULT, 32'h1, "ovf_result");
        wb_read(A_COUNT, 32'd2, "ovf_count");
        wb_read(A_STATUS, 32'h0000_040A, "ovf_status");
        chk("ovf_irq", {29'b0, irq}, 32'd0);

        // Overfill: 17th push dropped, err set.
        wb_write(A_CTRL, 32'h2, 4'hF);
        msum = '0; movf = 1'b0;
        for (int i = 0; i < 17; i++) begin
            words[i] = $urandom;
            wb_write(A_PUSH, words[i], 4'hF);
            if (i < 16) begin
                msum = {1'b0, msum[31:0]} + {1'b0, words[i]};
                if (msum[32]) movf = 1'b1;
            end
        end
        wb_read(A_STATUS, 32'h0000_0904, "full_status");
        wb_write(A_CTRL, 32'h1, 4'hF);
        idle(30);
        wb_read(A_COUNT, 32'd16, "full_count");
        wb_read(A_RESULT, msum[31:0], "full_result");
        wb_read(A_STATUS, 32'h0000_080A | {21'b0, movf, 10'b0}, "full_status2");

        // Clear aborts a run in progress.
        wb_write(A_CTRL, 32'h2, 4'hF);
        for (int i = 0; i < 8; i++) wb_write(A_PUSH, 32'h100 + i, 4'hF);
        wb_write(A_CTRL, 32'h5, 4'hF);
        wb_write(A_CTRL, 32'h2, 4'hF);
        wb_read(A_STATUS, 32'h0000_0008, "clr_status");
        wb_read(A_RESULT, 32'h0, "clr_result");
        wb_read(A_COUNT, 32'h0, "clr_count");
        chk("clr_irq", {29'b0, irq}, 32'd0);

        // Partial-select writes and out-of-window accesses do nothing.
        wb_write(A_PUSH, 32'hDEAD, 4'h3);
        wb_read(A_STATUS, 32'h0000_0008, "sel_status");
        acks = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0000_0000; dat_i = 32'h5; sel = 4'hF;
        repeat (4) begin @(posedge clk); #1; if (ack) acks++; end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        chk("oow_ack", acks, 32'd0);
        wb_read(A_STATUS, 32'h0000_0008, "oow_status");
        wb_read(32'h3000_0014, 32'h0, "unmapped");
        wb_read(A_PUSH, 32'h0, "push_read");

        // Start on empty FIFO, then irq falls with irq_en.
        wb_write(A_CTRL, 32'h5, 4'hF);
        wb_read(A_STATUS, 32'h0000_000A, "empty_status");
        wb_read(A_RESULT, 32'h0, "empty_result");
        chk("empty_irq", {29'b0, irq}, 32'd1);
        wb_write(A_CTRL, 32'h0, 4'hF);
        chk("irqen_off", {29'b0, irq}, 32'd0);

        // Asynchronous reset mid-run on 10 operands.
        for (int i = 0; i < 10; i++) wb_write(A_PUSH, 32'd1 + i, 4'hF);
        wb_write(A_CTRL, 32'h5, 4'hF);
        wb_read(A_CTRL, 32'h4, "pre_rst_ctrl");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_ack", {31'b0, ack}, 32'd0);
        chk("async_dat", dat_o, 32'd0);
        chk("async_irq", {29'b0, irq}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        wb_read(A_STATUS, 32'h0000_0008, "post_rst_status");
        wb_read(A_COUNT, 32'h0, "post_rst_count");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
